// File: rtl/bq_ctrl.sv
// -----------------------------------------------------------------------------
// bq_ctrl -- Wishbone control block for a biquad filter datapath.
//
// Holds the sample-rate divider, a shadow/active coefficient pair, the sample
// sequencing FSM and the status/interrupt logic.  The datapath itself lives
// outside: this block hands it a latched sample plus a start pulse and
// collects the result.
//
// Ports
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i,  Wishbone slave: single-cycle-latency ack, registered
//   wb_we_i, wb_adr_i,   read data, full-word access (wb_sel_i ignored)
//   wb_dat_i, wb_sel_i,
//   wb_ack_o, wb_dat_o
//   x_i / x_o            sample source / sample latched on each start pulse
//   smp_stb_o            one-cycle start pulse to the datapath
//   bq_done_i / y_i      datapath result strobe and value
//   y_o                  last captured result
//   coef_o               active coefficients {a2,a1,b2,b1,b0}, b0 in LSBs
//   irq_o                registered IRQ_EN & (DONE | OVR)
// -----------------------------------------------------------------------------
module bq_ctrl #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          DW       = 12,
    parameter int          CW       = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [31:0]     wb_adr_i,
    input  logic [31:0]     wb_dat_i,
    input  logic [3:0]      wb_sel_i,
    output logic            wb_ack_o,
    output logic [31:0]     wb_dat_o,
    input  logic [DW-1:0]   x_i,
    output logic [DW-1:0]   x_o,
    output logic            smp_stb_o,
    input  logic            bq_done_i,
    input  logic [DW-1:0]   y_i,
    output logic [DW-1:0]   y_o,
    output logic [5*CW-1:0] coef_o,
    output logic            irq_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_e;

    // Word offsets (byte offset >> 2)
    localparam logic [5:0] W_CTRL   = 6'h00;
    localparam logic [5:0] W_DIV    = 6'h01;
    localparam logic [5:0] W_STATUS = 6'h02;
    localparam logic [5:0] W_Y      = 6'h03;
    localparam logic [5:0] W_CNT    = 6'h09;

    state_e                 state_q, state_d;
    logic                   en_q, en_d;
    logic                   irq_en_q, irq_en_d;
    logic                   pend_q, pend_d;
    logic [15:0]            div_q, div_d;
    logic [15:0]            div_cnt_q, div_cnt_d;
    logic [31:0]            cnt_q, cnt_d;
    logic                   ovr_q, ovr_d;
    logic                   done_q, done_d;
    logic [4:0][CW-1:0]     shadow_q, shadow_d;
    logic [4:0][CW-1:0]     coef_q, coef_d;
    logic [DW-1:0]          x_q, x_d;
    logic [DW-1:0]          y_q, y_d;
    logic                   stb_q, stb_d;
    logic                   ack_q, ack_d;
    logic [31:0]            dat_q, dat_d;
    logic                   irq_q, irq_d;

    logic                   sel;
    logic                   bus_wr;
    logic                   tick;
    logic [5:0]             word;
    logic [2:0]             sh_idx;
    logic [31:0]            rdata;
    logic                   commit_wr, commit_now;
    logic                   ovr_set, ovr_clr, done_set, done_clr;

    // Byte lanes and the unused upper/lower address and data bits are
    // deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i[31:16]};

    // Masking with !ack_q keeps a still-asserted strobe from being taken twice.
    assign sel    = wb_cyc_i & wb_stb_i & (wb_adr_i[31:8] == BASE_ADR[31:8]) & ~ack_q;
    assign bus_wr = sel & wb_we_i;
    assign word   = wb_adr_i[7:2];
    assign sh_idx = word[2:0] - 3'd4;   // 0x10..0x20 -> shadow 0..4
    assign tick   = en_q & (div_cnt_q == div_q);

    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // left one unassigned would infer a latch.
        state_d    = state_q;
        en_d       = en_q;
        irq_en_d   = irq_en_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        coef_d     = coef_q;
        x_d        = x_q;
        y_d        = y_q;
        stb_d      = 1'b0;
        rdata      = '0;
        commit_wr  = 1'b0;
        commit_now = 1'b0;
        ovr_set    = 1'b0;
        ovr_clr    = 1'b0;
        done_set   = 1'b0;
        done_clr   = 1'b0;

        // Divider: 0..DIV while enabled, parked at 0 otherwise.
        if (!en_q || tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 16'd1;
        end

        unique case (word)
            W_CTRL:   rdata = {29'd0, irq_en_q, pend_q, en_q};
            W_DIV:    rdata = {16'd0, div_q};
            W_STATUS: rdata = {28'd0, done_q, ovr_q, (state_q == S_RUN), pend_q};
            W_Y:      rdata = 32'($signed(y_q));
            6'h04, 6'h05, 6'h06, 6'h07, 6'h08:
                      rdata = 32'(shadow_q[sh_idx]);
            W_CNT:    rdata = cnt_q;
            default:  rdata = '0;
        endcase

        if (bus_wr) begin
            unique case (word)
                W_CTRL: begin
                    en_d      = wb_dat_i[0];
                    irq_en_d  = wb_dat_i[2];
                    commit_wr = wb_dat_i[1];
                end
                W_DIV:    div_d = wb_dat_i[15:0];
                W_STATUS: begin
                    ovr_clr  = wb_dat_i[2];
                    done_clr = wb_dat_i[3];
                end
                6'h04, 6'h05, 6'h06, 6'h07, 6'h08:
                          shadow_d[sh_idx] = wb_dat_i[CW-1:0];
                default: ;
            endcase
        end

        unique case (state_q)
            S_IDLE: begin
                if (en_q) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    state_d = S_RUN;
                    stb_d   = 1'b1;
                    x_d     = x_i;
                    if (pend_q) begin
                        // Copies the pre-write shadow if a bus write lands now.
                        coef_d     = shadow_q;
                        commit_now = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // A tick here has no sample slot: flag overrun, stay in RUN.
                if (tick) ovr_set = 1'b1;
                if (bq_done_i) begin
                    y_d      = y_i;
                    cnt_d    = cnt_q + 32'd1;
                    done_set = 1'b1;
                    state_d  = en_q ? S_ARMED : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Hardware set beats a same-cycle bus clear; a COMMIT write beats a
        // same-cycle hardware commit.
        pend_d = (pend_q & ~commit_now) | commit_wr;
        ovr_d  = (ovr_q & ~ovr_clr) | ovr_set;
        done_d = (done_q & ~done_clr) | done_set;

        ack_d = sel;
        dat_d = (sel && !wb_we_i) ? rdata : '0;
        irq_d = irq_en_q & (done_q | ovr_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            pend_q    <= 1'b0;
            div_q     <= '0;
            div_cnt_q <= '0;
            cnt_q     <= '0;
            ovr_q     <= 1'b0;
            done_q    <= 1'b0;
            // NOTE: the shadow and coefficient arrays are plain flops and are
            // reset so the datapath never sees undefined coefficients.
            shadow_q  <= '0;
            coef_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            stb_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            pend_q    <= pend_d;
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
            cnt_q     <= cnt_d;
            ovr_q     <= ovr_d;
            done_q    <= done_d;
            shadow_q  <= shadow_d;
            coef_q    <= coef_d;
            x_q       <= x_d;
            y_q       <= y_d;
            stb_q     <= stb_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            irq_q     <= irq_d;
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
    assign x_o       = x_q;
    assign smp_stb_o = stb_q;
    assign y_o       = y_q;
    assign coef_o    = coef_q;
    assign irq_o     = irq_q;

endmodule
